// File: rtl/tri_pkg.sv
// Shared types and fixed-point constants for the triangle cosine engine.
package tri_pkg;
    localparam int LEN_W = 8;
    localparam int COS_W = 16;
    localparam int FRAC  = 13;
    localparam int QW    = FRAC + 1;
    localparam int NUM_W = 18;
    localparam int DEN_W = 17;
    localparam int DVD_W = 31;

    typedef enum logic [1:0] {
        TRI_ACUTE  = 2'b00,
        TRI_RIGHT  = 2'b01,
        TRI_OBTUSE = 2'b10
    } tri_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PREP,
        DIV,
        OUT
    } state_t;
endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per cycle; the first
// bit is resolved on the start edge so done follows QW edges after start.
module seq_divider
    import tri_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic             done,
    output logic [QW-1:0]    quotient
);
    localparam int CNT_W = $clog2(QW);

    logic [DEN_W-1:0] rem_q, rem_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [QW-1:0]    sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DEN_W-1:0] rem_in;
    logic [DEN_W-1:0] den_in;
    logic             bit_in;
    logic [DEN_W:0]   step_r;

    // Returns {quotient_bit, new_remainder}; remainder stays below the divisor.
    function automatic logic [DEN_W:0] div_step(input logic [DEN_W-1:0] rem,
                                                input logic             nxt,
                                                input logic [DEN_W-1:0] den);
        logic [DEN_W:0] trial;
        trial = {rem, nxt};
        if (trial >= {1'b0, den})
            return {1'b1, DEN_W'(trial - {1'b0, den})};
        else
            return {1'b0, trial[DEN_W-1:0]};
    endfunction

    always_comb begin
        rem_in = start ? dividend[DVD_W-1:QW] : rem_q;
        bit_in = start ? dividend[QW-1]       : sh_q[QW-1];
        den_in = start ? divisor              : den_q;
        step_r = div_step(rem_in, bit_in, den_in);

        rem_d  = rem_q;
        den_d  = den_q;
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            rem_d  = step_r[DEN_W-1:0];
            den_d  = divisor;
            sh_d   = {dividend[QW-2:0], step_r[DEN_W]};
            cnt_d  = CNT_W'(QW - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = step_r[DEN_W-1:0];
            sh_d  = {sh_q[QW-2:0], step_r[DEN_W]};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            den_q  <= '0;
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            den_q  <= den_d;
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = sh_q;
endmodule

// File: rtl/tri_cos_engine.sv
// Law-of-cosines engine: takes three serial side lengths, emits three signed
// Q2.13 cosines and the acute/right/obtuse class on the first output beat.
module tri_cos_engine
    import tri_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [LEN_W-1:0]        in_length,
    output logic                    out_valid,
    output logic signed [COS_W-1:0] out_cos,
    output logic [1:0]              out_tri
);
    state_t                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [LEN_W-1:0]        len_q [3];
    logic [LEN_W-1:0]        len_d [3];
    logic signed [NUM_W-1:0] num_q [3];
    logic signed [NUM_W-1:0] num_d [3];
    logic [DEN_W-1:0]        den_q [3];
    logic [DEN_W-1:0]        den_d [3];
    logic signed [COS_W-1:0] cos_q [3];
    logic signed [COS_W-1:0] cos_d [3];
    tri_t                    cls_q, cls_d;
    logic                    kick_q, kick_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [COS_W-1:0] out_cos_q, out_cos_d;
    tri_t                    out_tri_q, out_tri_d;

    logic                    div_start;
    logic                    div_done;
    logic [QW-1:0]           div_quot;
    logic [1:0]              div_sel;
    logic [DVD_W-1:0]        div_dividend;

    // opp is the side facing the angle; N = adj1^2 + adj2^2 - opp^2
    function automatic logic signed [NUM_W-1:0] law_num(input logic [LEN_W-1:0] opp,
                                                       input logic [LEN_W-1:0] adj1,
                                                       input logic [LEN_W-1:0] adj2);
        logic [NUM_W-1:0] o, x, y;
        o = NUM_W'(opp);
        x = NUM_W'(adj1);
        y = NUM_W'(adj2);
        return signed'(x * x + y * y - o * o);
    endfunction

    function automatic logic [DEN_W-1:0] law_den(input logic [LEN_W-1:0] adj1,
                                                 input logic [LEN_W-1:0] adj2);
        logic [DEN_W-1:0] x, y;
        x = DEN_W'(adj1);
        y = DEN_W'(adj2);
        return (x * y) << 1;
    endfunction

    function automatic logic [DEN_W-1:0] mag(input logic signed [NUM_W-1:0] n);
        return DEN_W'((n < 0) ? -n : n);
    endfunction

    // Negating the floored magnitude truncates toward zero.
    function automatic logic signed [COS_W-1:0] apply_sign(input logic [QW-1:0] q,
                                                           input logic         neg);
        logic signed [COS_W-1:0] m;
        m = signed'(COS_W'(q));
        return neg ? -m : m;
    endfunction

    always_comb begin
        div_sel = (state_q == DIV && div_done && idx_q != 2'd2) ? idx_q + 2'd1 : 2'd0;
        div_dividend = {1'b0, mag(num_q[div_sel]), {FRAC{1'b0}}};
        div_start = kick_q | (state_q == DIV && div_done && idx_q != 2'd2);
    end

    seq_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (den_q[div_sel]),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        num_d       = num_q;
        den_d       = den_q;
        cos_d       = cos_q;
        cls_d       = cls_q;
        kick_d      = 1'b0;
        out_valid_d = 1'b0;
        out_cos_d   = '0;
        out_tri_d   = TRI_ACUTE;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    len_d[0] = in_length;
                    idx_d    = 2'd1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    len_d[idx_q] = in_length;
                    if (idx_q == 2'd2) begin
                        idx_d   = 2'd0;
                        state_d = PREP;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            PREP: begin
                num_d[0] = law_num(len_q[0], len_q[1], len_q[2]);
                num_d[1] = law_num(len_q[1], len_q[2], len_q[0]);
                num_d[2] = law_num(len_q[2], len_q[0], len_q[1]);
                den_d[0] = law_den(len_q[1], len_q[2]);
                den_d[1] = law_den(len_q[2], len_q[0]);
                den_d[2] = law_den(len_q[0], len_q[1]);
                if (num_d[0] < 0 || num_d[1] < 0 || num_d[2] < 0)
                    cls_d = TRI_OBTUSE;
                else if (num_d[0] == 0 || num_d[1] == 0 || num_d[2] == 0)
                    cls_d = TRI_RIGHT;
                else
                    cls_d = TRI_ACUTE;
                kick_d  = 1'b1;
                state_d = DIV;
            end
            DIV: begin
                if (div_done) begin
                    cos_d[idx_q] = apply_sign(div_quot, num_q[idx_q] < 0);
                    if (idx_q == 2'd2) begin
                        idx_d       = 2'd0;
                        state_d     = OUT;
                        out_valid_d = 1'b1;
                        out_cos_d   = cos_q[0];
                        out_tri_d   = cls_q;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            OUT: begin
                if (idx_q == 2'd2) begin
                    idx_d   = 2'd0;
                    state_d = IDLE;
                end else begin
                    idx_d       = idx_q + 2'd1;
                    out_valid_d = 1'b1;
                    out_cos_d   = cos_q[idx_q + 2'd1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '{default: '0};
            num_q       <= '{default: '0};
            den_q       <= '{default: '0};
            cos_q       <= '{default: '0};
            cls_q       <= TRI_ACUTE;
            kick_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_cos_q   <= '0;
            out_tri_q   <= TRI_ACUTE;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            num_q       <= num_d;
            den_q       <= den_d;
            cos_q       <= cos_d;
            cls_q       <= cls_d;
            kick_q      <= kick_d;
            out_valid_q <= out_valid_d;
            out_cos_q   <= out_cos_d;
            out_tri_q   <= out_tri_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_cos   = out_cos_q;
    assign out_tri   = out_tri_q;
endmodule

// File: tb/tb_tri_cos_engine.sv
// Directed and randomized checks of tri_cos_engine cosines, class, timing and reset.
module tb_tri_cos_engine;
    import tri_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic [LEN_W-1:0]        in_length;
    logic                    out_valid;
    logic signed [COS_W-1:0] out_cos;
    logic [1:0]              out_tri;

    int n_checks = 0;
    int n_fail   = 0;

    int lat;
    int cs [3];
    int ts [3];
    int vs [3];
    int v_end;

    always #5 clk = ~clk;

    tri_cos_engine dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_length (in_length),
        .out_valid (out_valid),
        .out_cos   (out_cos),
        .out_tri   (out_tri)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output bus must be idle-zero, and never valid while input is valid.
    always @(negedge clk) begin
        if (in_valid === 1'b1) begin
            n_checks++;
            assert (out_valid === 1'b0) else begin
                n_fail++;
                $error("FAIL overlap: observed out_valid=%0b expected 0", out_valid);
            end
        end
        if (out_valid === 1'b0) begin
            n_checks++;
            assert (out_cos === 16'sd0 && out_tri === 2'b00) else begin
                n_fail++;
                $error("FAIL idle_zero: observed cos=%0d tri=%0d expected 0/0", out_cos, out_tri);
            end
        end
    end

    task automatic send(input int a, input int b, input int c);
        in_valid  = 1'b1;
        in_length = LEN_W'(a);
        @(posedge clk); #1;
        in_length = LEN_W'(b);
        @(posedge clk); #1;
        in_length = LEN_W'(c);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_length = '0;
    endtask

    task automatic collect();
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int k = 0; k < 3; k++) begin
            vs[k] = int'(out_valid);
            cs[k] = int'(out_cos);
            ts[k] = int'(out_tri);
            @(posedge clk); #1;
        end
        v_end = int'(out_valid);
    endtask

    task automatic run_dir(input string tag, input int a, input int b, input int c,
                           input int etri, input int e0, input int e1, input int e2);
        send(a, b, c);
        collect();
        chk({tag, "_lat"}, lat, 44);
        chk({tag, "_tri0"}, ts[0], etri);
        chk({tag, "_tri12"}, ts[1] + ts[2], 0);
        chk({tag, "_cos0"}, cs[0], e0);
        chk({tag, "_cos1"}, cs[1], e1);
        chk({tag, "_cos2"}, cs[2], e2);
        chk({tag, "_beats"}, vs[0] + vs[1] + vs[2], 3);
        chk({tag, "_end"}, v_end, 0);
        @(posedge clk); #1;
    endtask

    function automatic int exp_cls(input int a, input int b, input int c);
        int na, nb, nc;
        na = b*b + c*c - a*a;
        nb = c*c + a*a - b*b;
        nc = a*a + b*b - c*c;
        if (na < 0 || nb < 0 || nc < 0) return 2;
        if (na == 0 || nb == 0 || nc == 0) return 1;
        return 0;
    endfunction

    function automatic int cos_ok(input int got, input int opp, input int x, input int y);
        real cr, err;
        cr  = real'(x*x + y*y - opp*opp) / real'(2*x*y);
        err = real'(got) / 8192.0 - cr;
        if (err < 0.0) err = -err;
        return (err < 1.0 / 8192.0) ? 1 : 0;
    endfunction

    initial begin
        int seen;
        int a, b, c, lo, hi;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_length = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_cos", out_cos, 0);
        chk("rst_tri", out_tri, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_dir("t345", 3, 4, 5, 1, 6553, 4915, 0);
        run_dir("t555", 5, 5, 5, 0, 4096, 4096, 4096);
        run_dir("t423", 4, 2, 3, 2, -2048, 7168, 5632);
        run_dir("t1_255", 1, 255, 255, 0, 8191, 16, 16);
        run_dir("t255x3", 255, 255, 255, 0, 4096, 4096, 4096);

        // Abort during the division phase.
        send(6, 7, 8);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_div_valid", out_valid, 0);
        chk("abort_div_cos", out_cos, 0);
        chk("abort_div_tri", out_tri, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1;
        end
        chk("abort_div_noburst", seen, 0);
        run_dir("after_abort", 3, 4, 5, 1, 6553, 4915, 0);

        // Abort in the middle of an output burst: reset must clear outputs at once.
        send(3, 4, 5);
        seen = 0;
        while (out_valid !== 1'b1 && seen < 200) begin
            @(posedge clk); #1;
            seen++;
        end
        chk("abort_out_reached", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_cos", out_cos, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1;
        end
        chk("abort_out_noburst", seen, 0);

        for (int i = 0; i < 100; i++) begin
            a  = int'($urandom_range(255, 1));
            b  = int'($urandom_range(255, 1));
            lo = ((a > b) ? a - b : b - a) + 1;
            hi = a + b - 1;
            if (hi > 255) hi = 255;
            c  = int'($urandom_range(hi, lo));
            send(a, b, c);
            collect();
            chk($sformatf("rnd%0d_lat", i), lat, 44);
            chk($sformatf("rnd%0d_beats", i), vs[0] + vs[1] + vs[2] + (v_end == 0 ? 0 : 8), 3);
            chk($sformatf("rnd%0d_tri", i), ts[0], exp_cls(a, b, c));
            chk($sformatf("rnd%0d_err_a", i), cos_ok(cs[0], a, b, c), 1);
            chk($sformatf("rnd%0d_err_b", i), cos_ok(cs[1], b, c, a), 1);
            chk($sformatf("rnd%0d_err_c", i), cos_ok(cs[2], c, a, b), 1);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/tri_cos_engine.md
Name: tri_cos_engine

Overview:
- Computes the three interior-angle cosines of a triangle from three serially supplied 8-bit side lengths, and classifies it as acute, right or obtuse.
- It is the compute stage that the triangle pattern bench drives and checks.
- Inputs arrive as a 3-beat in_valid burst. Results leave as a 3-beat out_valid burst of signed fixed-point cosines, with the type on the first beat.
- A single shared sequential divider produces all three quotients.

Parameters:
- LEN_W, 8, side-length width.
- COS_W, 16, output cosine width (signed).
- FRAC, 13, fractional bits of out_cos (value = out_cos / 2^FRAC).

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- in_valid  in  1  high for exactly 3 consecutive cycles per triangle.
- in_length  in  LEN_W  side a, b, c on beats 0, 1, 2; unsigned, 1..255.
- out_valid  out  1  high for exactly 3 consecutive cycles per triangle.
- out_cos  out  COS_W  cosine of the angle opposite side a, b, c on out beats 0, 1, 2.
- out_tri  out  2  type: 2'b00 acute, 2'b01 right, 2'b10 obtuse; 2'b11 never driven.

Behaviour:
- Reset: out_valid=0, out_cos=0, out_tri=0, FSM to IDLE, length registers cleared. Asserting reset mid-operation aborts the current triangle immediately; outputs read 0 while reset is held. No output burst follows the aborted input.
- Input guarantees: lengths form a non-degenerate triangle (strict triangle inequality). The block does not check this.
- in_valid never asserts while the block is busy. If it does, it is ignored.
- FSM states: IDLE, LOAD, PREP, DIV, OUT.
  - IDLE -> LOAD on in_valid. Beat 0 is captured in the same cycle.
  - LOAD captures beats 1 and 2, then goes to PREP.
  - PREP (1 cycle) computes the three numerators and denominators, then goes to DIV.
  - DIV runs 3 divisions back-to-back, QW=FRAC+1 cycles each, in order a, b, c. Then goes to OUT.
  - OUT holds for 3 cycles, then returns to IDLE.
- Arithmetic, for the angle opposite side a (others by rotation):
  - N = b^2 + c^2 - a^2, signed, 18 bits.
  - D = 2*b*c, unsigned, 17 bits.
  - Quotient q = floor((|N| << FRAC) / D) via unsigned restoring division, 31-bit dividend.
  - out_cos = N<0 ? -q : q, i.e. truncation toward zero.
  - |cos| < 1 guarantees q <= 2^FRAC - 1, so no saturation logic is needed.
  - Required accuracy: |out_cos/8192 - true cos| < 2^-13.
- Classification, fixed in PREP:
  - any N < 0 -> obtuse;
  - else any N == 0 -> right;
  - else acute.
- Output timing:
  - out_valid rises exactly 3*QW + 2 cycles (44 at defaults) after the edge that samples beat 2.
  - out_tri carries the type on out beat 0 only; it is 0 on beats 1 and 2.
  - out_cos and out_tri are 0 whenever out_valid is 0.
  - out_valid never overlaps in_valid.
- Back-to-back: a new burst may begin on the cycle after out_valid falls. The 1-cycle gap used by the bench is supported.

Decomposition:
- Package tri_pkg holds:
  - tri_t enum (TRI_ACUTE=2'b00, TRI_RIGHT=2'b01, TRI_OBTUSE=2'b10);
  - FSM state enum;
  - constants LEN_W, COS_W, FRAC, QW.
- Sub-module seq_divider: unsigned restoring divider, 31-bit dividend, 17-bit divisor, QW-bit quotient.
  - Handshake: start pulse in, done pulse out after QW cycles.
  - Async active-high reset on the same rst.
  - One instance, reused three times.

Test Plan:
- 3,4,5 -> out_tri=01; out_cos = 6553, 4915, 0; latency exactly 44 cycles after beat 2.
- 5,5,5 -> out_tri=00; out_cos = 4096, 4096, 4096.
- 4,2,3 -> out_tri=10; out_cos = -2048, 7168, 5632 (negative truncated toward zero).
- 1,255,255 -> out_tri=00; out_cos = 8191, 16, 16 (near-unity and tiny-quotient truncation). Also 255,255,255 -> 4096 x3.
- Reset pulse during DIV of 6,7,8 -> all outputs 0 immediately and no out_valid afterwards. Next triangle 3,4,5 is correct.
- 100 random valid triangles sent back-to-back with 1 idle cycle between them. Each must give exactly 3 out_valid beats, no overlap with in_valid, and every |err| < 2^-13 against a real-valued model.
